pri_enc_q: RTL and testbench

//  Sequential N-to-log2(N) encoder: the inverse of the 3-to-8 decoder. It captures one-hot or

---
 rtl/pri_enc_q.sv | 143 ++++++++++++++
 tb/tb_pri_enc_q.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_enc_q.sv
// pri_enc_q: sequential N-to-log2(N) priority encoder with a valid/ready output handshake.
//
// Request pulses on in_i are collected in a pending register. Pending requests are offered
// one at a time as a binary index on out_o/valid_o. An offered bit stays pending until the
// consumer accepts it (valid_o && ready_i at a rising edge).
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       synchronous, active-high reset
//   in_i        [N-1:0] request pulses; bit i high for one cycle marks request i pending
//   out_o       [W-1:0] binary index of the offered request
//   valid_o     out_o holds a valid offered index
//   ready_i     consumer accepts the offered index
//   pending_o   [N-1:0] registered pending vector (includes the offered bit until accepted)
//   overflow_o  one-cycle pulse: a request arrived for a bit that was already pending
//
// Configuration macro:
//   PRI_ENC_Q_ROUND_ROBIN_EN  defined: rotating priority, search starts one past the last
//                             accepted index. Undefined: fixed priority, bit 0 highest.

module pri_enc_q #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] in_i,
    output logic [W-1:0] out_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StOffer = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [N-1:0] pending_q, pending_d;
    logic         overflow_q, overflow_d;

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] rem;
    logic [W-1:0] start_idle;
    logic [W-1:0] start_acc;

    // First set bit of vec, searching upward from start and wrapping modulo N.
    // N is a power of two, so W-bit addition wraps for free.
    function automatic logic [W-1:0] sel_idx(input logic [N-1:0] vec,
                                             input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic         found;
        sel_idx = start;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = start + W'(k);
            if (!found && vec[idx]) begin
                sel_idx = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign accept = (state_q == StOffer) && ready_i;

    always_comb begin
        clr = '0;
        if (accept) begin
            clr = {{(N-1){1'b0}}, 1'b1} << out_q;
        end
    end

    assign rem        = pending_q & ~clr;
    // Set wins over clear: a same-cycle re-request keeps the bit pending.
    assign pending_d  = rem | in_i;
    assign overflow_d = |(in_i & rem);

`ifdef PRI_ENC_Q_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Pointer holds (last accepted index + 1); moves only on accept.
    assign ptr_d      = accept ? out_q + W'(1) : ptr_q;
    assign start_idle = ptr_q;
    assign start_acc  = out_q + W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start_idle = '0;
    assign start_acc  = '0;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    out_d   = sel_idx(pending_q, start_idle);
                    state_d = StOffer;
                end
            end
            StOffer: begin
                // Held stable while !ready_i; new requests never preempt the offer.
                if (ready_i) begin
                    if (|rem) begin
                        out_d = sel_idx(rem, start_acc);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            out_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_o      = out_q;
    assign valid_o    = (state_q == StOffer);
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pri_enc_q.sv
// Self-checking bench for pri_enc_q (default build, fixed priority).
// Inputs change 1 time unit after each rising edge; checks happen at that same point.
// A negedge monitor scores every transfer against a queue of expected indices.

module tb_pri_enc_q;

    logic       clk;
    logic       rst_i;
    logic [7:0] in_i;
    logic [2:0] out_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] pending_o;
    logic       overflow_o;

    int         n_tests;
    int         n_fail;
    logic [2:0] exp_q[$];
    logic [2:0] sb_exp;

    pri_enc_q #(
        .N(8),
        .W(3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .in_i      (in_i),
        .out_o     (out_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pending_o (pending_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer happens at the next rising edge when valid && ready && !rst.
    always @(negedge clk) begin
        if (!rst_i && valid_o === 1'b1 && ready_i === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got index %0d, want no transfer", out_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out_o !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_order: got index %0d, want %0d", out_o, sb_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got none want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        in_i    = 8'h00;
        ready_i = 1'b0;
        tick();
        tick();
        n_tests++;
        if (pending_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_pending: got %h want 00", pending_o);
        end
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        n_tests++;
        if (out_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_out: got %0d want 0", out_o);
        end
        n_tests++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ready_i = 1'b1;
        in_i    = 8'h20;
        exp_q.push_back(3'd5);
        tick();
        in_i = 8'h00;
        n_tests++;
        if (pending_o !== 8'h20 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latch: got pending %h valid %b want 20/0", pending_o, valid_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd5) begin
            n_fail++; $display("FAIL single_offer: got valid %b out %0d want 1/5", valid_o, out_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL single_drain: got valid %b pending %h want 0/00", valid_o, pending_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_hold();
        in_i = 8'hA4;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd7);
        tick();
        in_i = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (valid_o !== 1'b1 || out_o !== 3'd2) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got valid %b out %0d want 1/2", i, valid_o, out_o);
            end
            tick();
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd5) begin
            n_fail++; $display("FAIL hold_b2b_5: got valid %b out %0d want 1/5", valid_o, out_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd7) begin
            n_fail++; $display("FAIL hold_b2b_7: got valid %b out %0d want 1/7", valid_o, out_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL hold_drain: got valid %b pending %h want 0/00", valid_o, pending_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_no_preempt();
        in_i = 8'h08;
        exp_q.push_back(3'd3);
        tick();
        in_i = 8'h00;
        tick();
        in_i = 8'h01;
        exp_q.push_back(3'd0);
        tick();
        in_i = 8'h00;
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd3 || pending_o !== 8'h09) begin
            n_fail++;
            $display("FAIL nopre_hold: got valid %b out %0d pending %h want 1/3/09",
                     valid_o, out_o, pending_o);
        end
        tick();
        n_tests++;
        if (out_o !== 3'd3) begin
            n_fail++; $display("FAIL nopre_hold2: got out %0d want 3", out_o);
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd0) begin
            n_fail++; $display("FAIL nopre_next: got valid %b out %0d want 1/0", valid_o, out_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL nopre_drain: got valid %b want 0", valid_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        in_i = 8'h10;
        exp_q.push_back(3'd4);
        tick();
        in_i = 8'h00;
        tick();
        // Re-request in the accept cycle: set wins, no overflow.
        ready_i = 1'b1;
        in_i    = 8'h10;
        exp_q.push_back(3'd4);
        tick();
        in_i    = 8'h00;
        ready_i = 1'b0;
        n_tests++;
        if (pending_o !== 8'h10 || overflow_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_setwins: got pending %h ovf %b valid %b want 10/0/0",
                     pending_o, overflow_o, valid_o);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd4) begin
            n_fail++; $display("FAIL ovf_reoffer: got valid %b out %0d want 1/4", valid_o, out_o);
        end
        in_i = 8'h10;
        tick();
        in_i = 8'h00;
        n_tests++;
        if (overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_pulse: got %b want 1", overflow_o);
        end
        tick();
        n_tests++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_oneshot: got %b want 0", overflow_o);
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_drain: got valid %b pending %h want 0/00", valid_o, pending_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b1;
        in_i    = 8'hFF;
        exp_q.push_back(3'd0);
        tick();
        in_i = 8'h00;
        tick();
        tick();
        n_tests++;
        if (valid_o !== 1'b1 || out_o !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_pre: got valid %b out %0d want 1/1", valid_o, out_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_tests++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00 || out_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got valid %b pending %h out %0d want 0/00/0",
                     valid_o, pending_o, out_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet[%0d]: got valid %b want 0", i, valid_o);
            end
        end
        ready_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_i   = 1'b1;
        in_i    = 8'h00;
        ready_i = 1'b0;
        test_reset();
        test_single();
        test_hold();
        test_no_preempt();
        test_overflow();
        test_reset_mid();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
